// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO writes.
// Signed ops work on operand magnitudes, and the signs are corrected at the end.
// Multiply is shift-add and divide is restoring. Each uses one operand bit per cycle.
// Optional macro MIPS_MULDIV_FAST_MULT_EN: MULT/MULTU use a single combinational
// multiplier and skip the RUN state. Divide is unchanged.
module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, dbz_q, dbz_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [W-1:0]         opa_q, opa_d, opb_q, opb_d;
    logic [2*W-1:0]       work_q, work_d;

    logic                 sgn_op, sa, sb;
    logic [W-1:0]         mag_a, mag_b;
    logic [W:0]           mul_sum, div_shl, div_diff;
    logic [2*W-1:0]       prod_mag, prod_res;

    // Two's-complement negate when n is set (single and double width).
    function automatic logic [W-1:0] cneg(input logic [W-1:0] v, input logic n);
        return n ? (~v + W'(1)) : v;
    endfunction

    function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] v, input logic n);
        return n ? (~v + (2*W)'(1)) : v;
    endfunction

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Next-state logic: issue, per-cycle multiply/divide step, final sign fix and write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        work_d   = work_q;
        sgn_op   = 1'b0;
        sa       = 1'b0;
        sb       = 1'b0;
        mag_a    = operand_a;
        mag_b    = operand_b;

        // Multiply: the upper half accumulates the multiplicand when the multiplier LSB is set.
        mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
        // Divide: shift the next dividend bit into the partial remainder, then trial-subtract.
        div_shl  = {work_q[2*W-1:W], work_q[W-1]};
        div_diff = div_shl - {1'b0, opb_q};

`ifdef MIPS_MULDIV_FAST_MULT_EN
        prod_mag = is_div_q ? work_q : ({{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q});
`else
        prod_mag = work_q;
`endif
        prod_res = cneg2(prod_mag, neg_q);

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        // MULT and DIV are the signed ops (op[0]=0).
                        sgn_op   = ~op[0];
                        sa       = sgn_op & operand_a[W-1];
                        sb       = sgn_op & operand_b[W-1];
                        mag_a    = cneg(operand_a, sa);
                        mag_b    = cneg(operand_b, sb);
                        is_div_d = op[1];
                        neg_d    = sa ^ sb;
                        rneg_d   = sa;
                        opa_d    = mag_a;
                        opb_d    = mag_b;
                        work_d   = {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt_d    = '0;
                        dbz_d    = 1'b0;
                        state_d  = S_RUN;
`ifdef MIPS_MULDIV_FAST_MULT_EN
                        if (!op[1]) state_d = S_FIX;
`endif
                    end else if (op[1:0] == 2'b00) begin
                        hi_d   = operand_a;
                        done_d = 1'b1;
                        dbz_d  = 1'b0;
                    end else if (op[1:0] == 2'b01) begin
                        lo_d   = operand_a;
                        done_d = 1'b1;
                        dbz_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q)
                        work_d = div_diff[W] ? {div_shl[W-1:0], work_q[W-2:0], 1'b0}
                                             : {div_diff[W-1:0], work_q[W-2:0], 1'b1};
                    else
                        work_d = {mul_sum, work_q[W-1:1]};
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(W - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!is_div_q) begin
                        hi_d = prod_res[2*W-1:W];
                        lo_d = prod_res[W-1:0];
                    end else if (opb_q == '0) begin
                        // Divide by zero: LO all ones, HI is the original dividend.
                        lo_d  = '1;
                        hi_d  = cneg(opa_q, rneg_q);
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = cneg(work_q[W-1:0], neg_q);
                        hi_d = cneg(work_q[2*W-1:W], rneg_q);
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural state: async reset to idle and zeroed outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Datapath working registers: only read in RUN/FIX, so they need no reset.
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
        work_q   <= work_d;
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit (DATA_WIDTH=32): directed and random ops against a
// longint arithmetic reference model.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mips_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ed = 1'b0;
        if (o == 3'd0) v = sa * sb;
        else if (o == 3'd1) v = ua * ub;
        else if (b == 32'd0) begin
            v  = {a, 32'hFFFF_FFFF};
            ed = 1'b1;
        end else if (o == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            v = {r[31:0], q[31:0]};
        end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            v = {r[31:0], q[31:0]};
        end
        eh = v[63:32];
        el = v[31:0];
    endtask

    // Issue a mul/div and wait for done. With inject set, a competing DIVU start
    // is pulsed mid-run and must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [31:0] eh, el;
        logic        ed;
        int          n, lat;
        model(o, a, b, eh, el, ed);
        lat = 34;
`ifdef MIPS_MULDIV_FAST_MULT_EN
        if (!o[1]) lat = 2;
`endif
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_dbz_clr"}, {63'd0, div_by_zero}, 64'd0);
        while (done !== 1'b1 && n < 200) begin
            if (inject && n == 5) begin
                start = 1'b1; op = 3'd3; operand_a = ~a; operand_b = b | 32'd1;
            end
            step();
            start = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        step();
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    // MTHI (o=4) / MTLO (o=5) single-cycle write.
    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        op = o; operand_a = v; start = 1'b1;
        step();
        start = 1'b0;
        chk("mt_done", {63'd0, done}, 64'd1);
        chk("mt_busy", {63'd0, busy}, 64'd0);
    endtask

    // Start an op, pulse an MTHI mid-run (ignored), flush in cycle 'at'; HI/LO keep their values.
    task automatic run_flush(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input int at);
        logic [31:0] h0, l0;
        int          n, dones;
        h0 = hi; l0 = lo; dones = 0;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (n < at) begin
            if (n == 4) begin
                start = 1'b1; op = 3'd4; operand_a = 32'hDEAD;
            end
            if (done === 1'b1) dones++;
            step();
            start = 1'b0;
            n++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        repeat (40) begin
            if (done === 1'b1) dones++;
            step();
        end
        chk({tag, "_no_done"}, 64'(dones), 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, h0});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, l0});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb, h0, l0;
        logic [2:0]  fop;
        int          ones;

        // Reset state
        repeat (2) step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        step();

        // Directed arithmetic
        run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_9_0", 3'd3, 32'd9, 32'd0, 1'b0);
        run_op("div_after_dbz", 3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0);
        run_op("div_neg_by_0", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_minneg", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Random ops, every other one with an ignored mid-run start
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 3) rb = rb >> $urandom_range(0, 31);
            run_op("rand", ro, ra, rb, 1'(i % 2));
        end

        // MTHI then MTLO on consecutive cycles
        op = 3'd4; operand_a = 32'h1234; start = 1'b1;
        step();
        chk("mthi_done", {63'd0, done}, 64'd1);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        op = 3'd5; operand_a = 32'hABCD;
        step();
        start = 1'b0;
        chk("mtlo_done", {63'd0, done}, 64'd1);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        chk("mtlo_lo", {32'd0, lo}, 64'hABCD);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        step();
        chk("mt_done_end", {63'd0, done}, 64'd0);

        // Reserved op: nothing happens
        h0 = hi; l0 = lo; ones = 0;
        op = 3'd6; operand_a = 32'h5555_AAAA; start = 1'b1;
        step();
        start = 1'b0;
        if (done === 1'b1 || busy === 1'b1) ones++;
        step();
        if (done === 1'b1 || busy === 1'b1) ones++;
        chk("rsvd_quiet", 64'(ones), 64'd0);
        chk("rsvd_hi", {32'd0, hi}, {32'd0, h0});
        chk("rsvd_lo", {32'd0, lo}, {32'd0, l0});

        // Flush in RUN (cycle 10) and in FIX (cycle 33), with HI=LO=5
        mt(3'd4, 32'd5);
        mt(3'd5, 32'd5);
        fop = 3'd0;
`ifdef MIPS_MULDIV_FAST_MULT_EN
        fop = 3'd3;
`endif
        run_flush("flush_run", fop, 32'd123, 32'd456, 10);
        run_flush("flush_fix", 3'd2, 32'd1000, 32'd7, 33);

        // Async reset mid-run clears every output before the next edge
        op = 3'd0; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_idle", {63'd0, busy}, 64'd0);
        run_op("post_rst", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
